conv2_pool_flatten: RTL and testbench
=====================================

CONV2_POOL_FLATTEN -- requirements
Module: conv2_pool_flatten

Interface
REQ-001 Parameter DATA_W, 16: signed width of conv2 samples and output features.
REQ-002 Parameter IN_DIM, 8: conv2 output map is IN_DIM x IN_DIM, row-major; must be even.
REQ-003 Parameter CH, 3: number of conv2 output channels.
REQ-004 i_clk  in  1: clock; all logic SHALL be on the rising edge.
REQ-005 i_rst  in  1: synchronous, active-low reset.
REQ-006 i_valid  in  1: conv2 sample valid (conv2_valid).
REQ-007 i_ch0 / i_ch1 / i_ch2  in  DATA_W each, signed: conv2 outputs for channels 0..2 of the current pixel.
REQ-008 o_in_ready  out  1: block accepts samples (COLLECT state).
REQ-009 o_feat_valid  out  1: flattened feature valid toward FC1.
REQ-010 i_feat_ready  in  1: FC1 accepts a feature.
REQ-011 o_feat_data  out  DATA_W, signed: feature value.
REQ-012 o_feat_idx  out  6: flat index, equal to ch*16 + prow*4 + pcol.
REQ-013 o_feat_last  out  1: high with the feature at index 47.
REQ-014 o_frame_done  out  1: one-cycle pulse after the last feature is accepted.
REQ-015 o_overflow  out  1: sticky flag, set when a sample arrives while o_in_ready is low.

Function
REQ-016 States: COLLECT and STREAM only; reset SHALL enter COLLECT.
REQ-017 COLLECT: o_in_ready=1; each cycle with i_valid=1 accepts one pixel (all CH channels); col counter 0..7, then row counter 0..7.
REQ-018 Even row, even col: hold each channel in a horizontal register h[ch].
REQ-019 Even row, odd col: lb[ch][col>>1] <= max(h[ch], sample) (signed compare).
REQ-020 Odd row, even col: h[ch] <= sample.
REQ-021 Odd row, odd col: feat[ch*16+(row>>1)*4+(col>>1)] <= relu(max(h[ch], sample, lb[ch][col>>1])), written in the acceptance cycle.
REQ-022 relu(x): x<0 gives 0, otherwise x; no width change and no saturation.
REQ-023 When the 64th pixel (row 7, col 7) is accepted: counters wrap to 0 and the FSM moves to STREAM on the next edge.
REQ-024 First o_feat_valid SHALL assert in the cycle after the 64th acceptance, with idx 0.
REQ-025 STREAM: o_feat_valid=1; data, idx and last SHALL hold stable until i_feat_ready=1.
REQ-026 STREAM: each valid&ready handshake increments idx; features are emitted in order 0..47.
REQ-027 Handshake at idx 47: next cycle o_feat_valid=0, o_frame_done=1, state=COLLECT.
REQ-028 Throughput: one feature per cycle when i_feat_ready is held high (48 cycles).
REQ-029 i_valid in STREAM: the sample is dropped, o_overflow is set, and counters are not changed.
REQ-030 o_overflow SHALL clear only on reset.
REQ-031 i_valid gaps in COLLECT SHALL stall the counters without losing h/lb contents.
REQ-032 i_feat_ready asserted while o_feat_valid=0 SHALL have no effect.

Reset
REQ-033 On i_rst=0 at a clock edge: state=COLLECT; row=col=idx=0.
REQ-034 On reset, outputs SHALL take these values: o_in_ready=1, o_feat_valid=0, o_feat_data=0, o_feat_idx=0, o_feat_last=0, o_frame_done=0, o_overflow=0.
REQ-035 Reset mid-COLLECT or mid-STREAM SHALL abandon the frame; feat, h and lb need not be cleared.

Structure
REQ-036 Shared package cnn_pkg SHALL hold: DATA_W, CONV2_OUT_DIM=8, CONV2_CH=3, POOL_DIM=4, FEAT_NUM=48, and the state enum {COLLECT, STREAM}.
REQ-037 One sub-module, pool_cmp, SHALL provide a combinational signed max-of-two; it is instantiated per channel.
REQ-038 Feature storage SHALL be a 48 x DATA_W register array, read by idx.

Verification
REQ-039 Ramp test: 64 pixels with ch0 = row*8+col, ch1 = -(row*8+col), ch2 = 5; i_feat_ready=1 -> idx0=9, idx15=63, idx16..31=0, idx32..47=5; last at idx47; frame_done one cycle later.
REQ-040 Back-pressure: toggle i_feat_ready every 3 cycles -> data and idx stable while stalled; exactly 48 handshakes.
REQ-041 Gapped input: insert random i_valid gaps during COLLECT -> features identical to the gap-free run.
REQ-042 Overflow: assert i_valid during STREAM -> o_overflow=1 and persists; the stream and the next frame are unaffected.
REQ-043 Reset at the 20th feature -> next cycle o_feat_valid=0, o_in_ready=1; a fresh frame then produces correct results.
REQ-044 Negative window: the four samples of a pooling window are -3, -7, -1, -9 -> feature=0; the window 100, -200, 32767, -32768 -> 32767.

Source files
------------

// File: rtl/conv2_pool_flatten_pkg.sv
// Shared CNN constants and the pool/flatten controller state type.
package cnn_pkg;

    localparam int DATA_W        = 16;
    localparam int CONV2_OUT_DIM = 8;
    localparam int CONV2_CH      = 3;
    localparam int POOL_DIM      = 4;
    localparam int FEAT_NUM      = 48;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        STREAM  = 1'b1
    } state_t;

endpackage

// File: rtl/conv2_pool_flatten_pool_cmp.sv
// Combinational signed max-of-two used by the 2x2 max-pool datapath.
module pool_cmp #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] i_a,
    input  logic signed [W-1:0] i_b,
    output logic signed [W-1:0] o_max
);

    // Both operands are signed, so this is a two's-complement compare.
    assign o_max = (i_a > i_b) ? i_a : i_b;

endmodule

// File: rtl/conv2_pool_flatten.sv
// 2x2 max-pool + ReLU over the conv2 output map, then stream the pooled
// features out in flat order ch*16 + prow*4 + pcol with valid/ready.
module conv2_pool_flatten #(
    parameter int DATA_W = 16,
    parameter int IN_DIM = 8,
    parameter int CH     = 3
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic signed [DATA_W-1:0] i_ch0,
    input  logic signed [DATA_W-1:0] i_ch1,
    input  logic signed [DATA_W-1:0] i_ch2,
    output logic                     o_in_ready,
    output logic                     o_feat_valid,
    input  logic                     i_feat_ready,
    output logic signed [DATA_W-1:0] o_feat_data,
    output logic [5:0]               o_feat_idx,
    output logic                     o_feat_last,
    output logic                     o_frame_done,
    output logic                     o_overflow
);

    import cnn_pkg::*;

    localparam int PD     = IN_DIM / 2;
    localparam int FEAT_N = CH * PD * PD;
    localparam int CW     = $clog2(IN_DIM);
    localparam int HW     = CW - 1;
    localparam logic [CW-1:0] LAST_POS = CW'(IN_DIM - 1);
    localparam logic [5:0]    LAST_IDX = 6'(FEAT_N - 1);

    // Control state
    state_t          r_state;
    logic [CW-1:0]   r_row;
    logic [CW-1:0]   r_col;
    logic [5:0]      r_idx;
    logic            r_frame_done;
    logic            r_overflow;

    // Datapath storage (not reset; a new frame overwrites everything it reads)
    logic signed [DATA_W-1:0] r_h    [CH];
    logic signed [DATA_W-1:0] r_lb   [CH][PD];
    logic signed [DATA_W-1:0] r_feat [FEAT_N];

    logic signed [DATA_W-1:0] w_smp  [CH];
    logic signed [DATA_W-1:0] w_hmax [CH];
    logic signed [DATA_W-1:0] w_vmax [CH];
    logic                     w_accept;
    logic [HW-1:0]            w_hcol;
    logic [HW-1:0]            w_hrow;
    logic [2*HW-1:0]          w_pos;

    function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
        return x[DATA_W-1] ? '0 : x;
    endfunction

    assign w_smp[0] = i_ch0;
    assign w_smp[1] = i_ch1;
    assign w_smp[2] = i_ch2;

    assign w_accept = i_valid && (r_state == COLLECT);
    assign w_hcol   = r_col[CW-1:1];
    assign w_hrow   = r_row[CW-1:1];
    assign w_pos    = {w_hrow, w_hcol};

    // Per channel: horizontal max of the pair, then fold in the line-buffered
    // max from the even row above to close the 2x2 window.
    for (genvar c = 0; c < CH; c++) begin : g_ch
        pool_cmp #(.W(DATA_W)) u_hmax (
            .i_a   (r_h[c]),
            .i_b   (w_smp[c]),
            .o_max (w_hmax[c])
        );
        pool_cmp #(.W(DATA_W)) u_vmax (
            .i_a   (w_hmax[c]),
            .i_b   (r_lb[c][w_hcol]),
            .o_max (w_vmax[c])
        );
    end

    // Controller: pixel counters in COLLECT, feature index in STREAM, flags.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= COLLECT;
            r_row        <= '0;
            r_col        <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            // A sample offered while not ready is dropped but remembered.
            if (i_valid && (r_state == STREAM)) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                COLLECT: begin
                    if (i_valid) begin
                        if (r_col == LAST_POS) begin
                            r_col <= '0;
                            if (r_row == LAST_POS) begin
                                r_row   <= '0;
                                r_state <= STREAM;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (i_feat_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx        <= '0;
                            r_state      <= COLLECT;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

    // Pooling datapath: position parity selects hold / line-buffer / commit.
    always_ff @(posedge i_clk) begin
        for (int c = 0; c < CH; c++) begin
            if (w_accept) begin
                case ({r_row[0], r_col[0]})
                    2'b00, 2'b10: r_h[c] <= w_smp[c];
                    2'b01:        r_lb[c][w_hcol] <= w_hmax[c];
                    2'b11:        r_feat[6'(c * PD * PD) + 6'(w_pos)] <= relu(w_vmax[c]);
                    default:      r_h[c] <= r_h[c];
                endcase
            end
        end
    end

    assign o_in_ready   = (r_state == COLLECT);
    assign o_feat_valid = (r_state == STREAM);
    assign o_feat_data  = o_feat_valid ? r_feat[r_idx] : '0;
    assign o_feat_idx   = r_idx;
    assign o_feat_last  = o_feat_valid && (r_idx == LAST_IDX);
    assign o_frame_done = r_frame_done;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_conv2_pool_flatten.sv
// Self-checking bench for conv2_pool_flatten against a frame-level
// max-pool/ReLU reference model.
module tb_conv2_pool_flatten;

    logic               i_clk;
    logic               i_rst;
    logic               i_valid;
    logic signed [15:0] i_ch0, i_ch1, i_ch2;
    logic               o_in_ready;
    logic               o_feat_valid;
    logic               i_feat_ready;
    logic signed [15:0] o_feat_data;
    logic [5:0]         o_feat_idx;
    logic               o_feat_last;
    logic               o_frame_done;
    logic               o_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    int pix [3][64];
    int expf[48];
    int got [48];
    int ref_run[48];

    conv2_pool_flatten #(.DATA_W(16), .IN_DIM(8), .CH(3)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .i_ch0        (i_ch0),
        .i_ch1        (i_ch1),
        .i_ch2        (i_ch2),
        .o_in_ready   (o_in_ready),
        .o_feat_valid (o_feat_valid),
        .i_feat_ready (i_feat_ready),
        .o_feat_data  (o_feat_data),
        .o_feat_idx   (o_feat_idx),
        .o_feat_last  (o_feat_last),
        .o_frame_done (o_frame_done),
        .o_overflow   (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic rand_frame();
        logic signed [15:0] r;
        for (int c = 0; c < 3; c++)
            for (int p = 0; p < 64; p++) begin
                r = 16'($urandom);
                pix[c][p] = int'(r);
            end
    endtask

    // Reference: max over each 2x2 window, ReLU, flatten ch-major.
    task automatic compute_expected();
        int m, v;
        for (int c = 0; c < 3; c++)
            for (int pr = 0; pr < 4; pr++)
                for (int pc = 0; pc < 4; pc++) begin
                    m = -100000;
                    for (int dy = 0; dy < 2; dy++)
                        for (int dx = 0; dx < 2; dx++) begin
                            v = pix[c][(2*pr+dy)*8 + 2*pc + dx];
                            if (v > m) m = v;
                        end
                    expf[c*16 + pr*4 + pc] = (m < 0) ? 0 : m;
                end
    endtask

    task automatic send_frame(input bit gaps);
        for (int p = 0; p < 64; p++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    i_valid = 1'b0;
                    i_ch0 = 16'($urandom); i_ch1 = 16'($urandom); i_ch2 = 16'($urandom);
                    tick();
                end
            end
            n_checks++;
            if (o_in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL in_ready_collect pix=%0d got=%b want=1", p, o_in_ready);
            end
            i_valid = 1'b1;
            i_ch0 = 16'(pix[0][p]); i_ch1 = 16'(pix[1][p]); i_ch2 = 16'(pix[2][p]);
            tick();
        end
        i_valid = 1'b0;
        n_checks++;
        if (o_feat_valid !== 1'b1 || o_feat_idx !== 6'd0) begin
            n_fail++;
            $display("FAIL first_valid got valid=%b idx=%0d want valid=1 idx=0", o_feat_valid, o_feat_idx);
        end
    endtask

    // Drain one frame. mode 0: ready held high; mode 1: ready toggles every 3 cycles.
    task automatic run_stream(input int mode, input bit inject, output int cycles);
        int hs = 0;
        int cyc = 0;
        bit stalled = 0;
        bit rdy;
        logic signed [15:0] pd;
        logic [5:0] pi;
        while (hs < 48 && cyc < 2000) begin
            if (stalled) begin
                n_checks++;
                if (o_feat_data !== pd || o_feat_idx !== pi) begin
                    n_fail++;
                    $display("FAIL stall_stable got data=%0d idx=%0d want data=%0d idx=%0d", o_feat_data, o_feat_idx, pd, pi);
                end
            end
            rdy = (mode == 0) ? 1'b1 : (((cyc / 3) % 2) == 0);
            i_feat_ready = rdy;
            i_valid = inject && ((cyc % 5) == 2);
            i_ch0 = 16'($urandom); i_ch1 = 16'($urandom); i_ch2 = 16'($urandom);
            n_checks++;
            if (o_feat_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_valid cyc=%0d got=%b want=1", cyc, o_feat_valid);
            end
            if (o_feat_valid && rdy) begin
                n_checks++;
                if (o_feat_idx !== 6'(hs) || o_feat_last !== (hs == 47)) begin
                    n_fail++;
                    $display("FAIL stream_order got idx=%0d last=%b want idx=%0d last=%b", o_feat_idx, o_feat_last, hs, (hs == 47));
                end
                got[hs] = int'(o_feat_data);
                hs++;
            end
            stalled = o_feat_valid && !rdy;
            pd = o_feat_data;
            pi = o_feat_idx;
            tick();
            cyc++;
        end
        i_valid = 1'b0;
        cycles = cyc;
        n_checks++;
        if (hs != 48) begin
            n_fail++;
            $display("FAIL stream_timeout handshakes=%0d want=48", hs);
        end
        n_checks++;
        if (o_feat_valid !== 1'b0 || o_frame_done !== 1'b1 || o_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_end got valid=%b done=%b in_ready=%b want 0 1 1", o_feat_valid, o_frame_done, o_in_ready);
        end
        tick();
        n_checks++;
        if (o_frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse got=%b want=0", o_frame_done);
        end
    endtask

    task automatic check_features(input string name);
        for (int i = 0; i < 48; i++) begin
            n_checks++;
            if (got[i] != expf[i]) begin
                n_fail++;
                $display("FAIL %s idx=%0d got=%0d want=%0d", name, i, got[i], expf[i]);
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        i_valid = 1'b1;
        i_feat_ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if (o_in_ready !== 1'b1 || o_feat_valid !== 1'b0 || o_feat_data !== 16'sd0 ||
            o_feat_idx !== 6'd0 || o_feat_last !== 1'b0 || o_frame_done !== 1'b0 || o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got rdy=%b v=%b d=%0d idx=%0d last=%b done=%b ovf=%b want 1 0 0 0 0 0 0",
                     o_in_ready, o_feat_valid, o_feat_data, o_feat_idx, o_feat_last, o_frame_done, o_overflow);
        end
        i_valid = 1'b0;
        i_rst = 1'b1;
        tick();
        n_checks++;
        if (o_in_ready !== 1'b1 || o_feat_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset got rdy=%b v=%b want 1 0", o_in_ready, o_feat_valid);
        end
    endtask

    task automatic test_ramp();
        int cyc;
        for (int p = 0; p < 64; p++) begin
            pix[0][p] = p;
            pix[1][p] = -p;
            pix[2][p] = 5;
        end
        compute_expected();
        send_frame(1'b0);
        run_stream(0, 1'b0, cyc);
        check_features("ramp_model");
        n_checks++;
        if (got[0] != 9 || got[15] != 63 || got[16] != 0 || got[31] != 0 || got[32] != 5 || got[47] != 5) begin
            n_fail++;
            $display("FAIL ramp_points got %0d %0d %0d %0d %0d %0d want 9 63 0 0 5 5",
                     got[0], got[15], got[16], got[31], got[32], got[47]);
        end
        n_checks++;
        if (cyc != 48) begin
            n_fail++;
            $display("FAIL throughput cycles=%0d want=48", cyc);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        rand_frame();
        compute_expected();
        // Ready high while collecting must not disturb anything.
        i_feat_ready = 1'b1;
        send_frame(1'b0);
        run_stream(1, 1'b0, cyc);
        check_features("backpressure");
    endtask

    task automatic test_gapped();
        int cyc;
        rand_frame();
        compute_expected();
        send_frame(1'b0);
        run_stream(0, 1'b0, cyc);
        check_features("gapfree");
        for (int i = 0; i < 48; i++) ref_run[i] = got[i];
        send_frame(1'b1);
        run_stream(0, 1'b0, cyc);
        check_features("gapped");
        for (int i = 0; i < 48; i++) begin
            n_checks++;
            if (got[i] != ref_run[i]) begin
                n_fail++;
                $display("FAIL gap_vs_nogap idx=%0d got=%0d want=%0d", i, got[i], ref_run[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int cyc;
        rand_frame();
        compute_expected();
        send_frame(1'b0);
        n_checks++;
        if (o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_clear got=%b want=0", o_overflow);
        end
        run_stream(0, 1'b1, cyc);
        check_features("overflow_stream");
        n_checks++;
        if (o_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set got=%b want=1", o_overflow);
        end
        rand_frame();
        compute_expected();
        send_frame(1'b0);
        run_stream(0, 1'b0, cyc);
        check_features("overflow_next");
        n_checks++;
        if (o_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky got=%b want=1", o_overflow);
        end
    endtask

    task automatic test_negative_window();
        int cyc;
        rand_frame();
        pix[0][0] = -3;  pix[0][1] = -7;   pix[0][8] = -1;    pix[0][9] = -9;
        pix[1][0] = 100; pix[1][1] = -200; pix[1][8] = 32767; pix[1][9] = -32768;
        compute_expected();
        send_frame(1'b0);
        run_stream(0, 1'b0, cyc);
        check_features("negwin_model");
        n_checks++;
        if (got[0] != 0 || got[16] != 32767) begin
            n_fail++;
            $display("FAIL negwin_points got %0d %0d want 0 32767", got[0], got[16]);
        end
    endtask

    task automatic test_reset_mid_stream();
        int cyc;
        rand_frame();
        compute_expected();
        send_frame(1'b0);
        i_feat_ready = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        n_checks++;
        if (o_feat_idx !== 6'd20 || o_feat_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_idx got idx=%0d v=%b want 20 1", o_feat_idx, o_feat_valid);
        end
        i_rst = 1'b0;
        tick();
        i_rst = 1'b1;
        n_checks++;
        if (o_feat_valid !== 1'b0 || o_in_ready !== 1'b1 || o_feat_idx !== 6'd0 || o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset got v=%b rdy=%b idx=%0d ovf=%b want 0 1 0 0",
                     o_feat_valid, o_in_ready, o_feat_idx, o_overflow);
        end
        rand_frame();
        compute_expected();
        send_frame(1'b1);
        run_stream(1, 1'b0, cyc);
        check_features("after_reset");
    endtask

    initial begin
        i_rst = 1'b0;
        i_valid = 1'b0;
        i_feat_ready = 1'b0;
        i_ch0 = '0; i_ch1 = '0; i_ch2 = '0;
        test_reset();
        test_ramp();
        test_backpressure();
        test_gapped();
        test_overflow();
        test_negative_window();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
